// File: rtl/filter_classify_if.sv
// filter_classify_if: RAM port-B read bus shared by the real and imaginary response RAMs.
//   rd_en    enable for both RAMs
//   rd_addr  bin address, common to both RAMs
//   rd_real  real word, RD_LAT cycles after the address
//   rd_imag  imaginary word, same timing
// master = the analyser that issues reads, slave = the RAM side.
interface filter_classify_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_real;
  logic [DATA_W-1:0] rd_imag;

  modport master (output rd_en, output rd_addr, input rd_real, input rd_imag);
  modport slave  (input rd_en, input rd_addr, output rd_real, output rd_imag);
endinterface

// File: rtl/filter_classify.sv
// filter_classify: post-learning analyser. Sweeps the learned complex response twice, first to
// find the peak magnitude (|re| + |im|), then to mark every bin against the -3 dB threshold
// (peak * 181 / 256), and classifies the network from the in-band segment pattern.
//   clk_50m      system clock
//   rst_n        asynchronous active-low reset
//   start        learn_done level, a run starts on its rising edge; dropping it aborts a run
//   ram          RAM port-B read bus (master side)
//   busy         high while a run is in progress
//   done         one-cycle pulse when the result outputs update
//   filter_type  0 unknown/all-pass, 1 LPF, 2 HPF, 3 BPF, 4 BSF
//   f_low        lower band-edge bin
//   f_high       upper band-edge bin
//   peak_mag     peak magnitude of the last completed run
module filter_classify #(
  parameter int unsigned N_PTS  = 2800,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RD_LAT = 2
) (
  input  logic                 clk_50m,
  input  logic                 rst_n,
  input  logic                 start,
  filter_classify_if.master    ram,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           filter_type,
  output logic [ADDR_W-1:0]    f_low,
  output logic [ADDR_W-1:0]    f_high,
  output logic [DATA_W:0]      peak_mag
);

  typedef enum logic [2:0] {StIdle, StPeak, StBand, StClass, StDone} state_e;

  // Each sweep issues N_PTS reads then waits RD_LAT cycles for the last data to return.
  localparam int unsigned       Sweep    = N_PTS + RD_LAT;
  localparam int unsigned       CntW     = $clog2(Sweep);
  localparam logic [CntW-1:0]   CntLast  = CntW'(Sweep - 1);
  localparam logic [CntW-1:0]   CntRdEnd = CntW'(N_PTS);
  localparam logic [ADDR_W-1:0] BinLast  = ADDR_W'(N_PTS - 1);
  localparam logic [DATA_W-1:0] SMin     = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] SMax     = {1'b0, {(DATA_W-1){1'b1}}};

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              start_q, trigger, sweeping, commit;
  logic [RD_LAT-1:0] vld_q;
  logic [ADDR_W-1:0] idx_q [RD_LAT];
  logic              smp_vld;
  logic [ADDR_W-1:0] smp_idx;
  logic [DATA_W-1:0] abs_re, abs_im;
  logic [DATA_W:0]   mag, pk_q, pk_d, thr_q, thr_d;
  logic [DATA_W+8:0] thr_prod;
  logic              in_band, prev_in_q, in_first_q, in_last_q;
  logic [1:0]        nseg_q;
  logic [ADDR_W-1:0] first_end_q, last_start_q;
  logic [2:0]        cls_type_d, cls_type_q;
  logic [ADDR_W-1:0] cls_lo_d, cls_lo_q, cls_hi_d, cls_hi_q;

  // The most negative word has no positive twin; clamp it instead of wrapping.
  function automatic logic [DATA_W-1:0] abs_sat(logic [DATA_W-1:0] x);
    if (x == SMin)         return SMax;
    else if (x[DATA_W-1])  return ~x + DATA_W'(1);
    else                   return x;
  endfunction

  assign trigger  = start & ~start_q;
  assign sweeping = (state_q == StPeak) || (state_q == StBand);
  assign busy     = (state_q != StIdle);
  assign commit   = (state_q == StDone) && start;

  assign ram.rd_en   = sweeping && (cnt_q < CntRdEnd);
  assign ram.rd_addr = ram.rd_en ? ADDR_W'(cnt_q) : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      StIdle:  if (trigger) state_d = StPeak;
      StPeak, StBand: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = (state_q == StPeak) ? StBand : StClass;
        end
      end
      StClass: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Losing learn_done mid-run abandons the run; the previous results stay on the outputs.
    if ((state_q != StIdle) && !start) begin
      state_d = StIdle;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start;
    end
  end

  // Valid/address pipeline pairs each returned RAM word with the bin it was read from.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) idx_q[i] <= '0;
    end else if (state_q == StIdle) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= ram.rd_en;
      idx_q[0] <= ram.rd_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign smp_vld  = vld_q[RD_LAT-1];
  assign smp_idx  = idx_q[RD_LAT-1];
  assign abs_re   = abs_sat(ram.rd_real);
  assign abs_im   = abs_sat(ram.rd_imag);
  assign mag      = {1'b0, abs_re} + {1'b0, abs_im};
  assign in_band  = (mag >= thr_q);
  assign thr_prod = (DATA_W+9)'(pk_d) * (DATA_W+9)'(181);
  assign thr_d    = thr_prod[DATA_W+8:8];

  // Strictly greater keeps the earlier bin on ties.
  always_comb begin
    pk_d = pk_q;
    if ((state_q == StPeak) && smp_vld && (mag > pk_q)) pk_d = mag;
  end

  always_comb begin
    cls_type_d = 3'd0;
    cls_lo_d   = '0;
    cls_hi_d   = '0;
    if (pk_q == '0) begin
      cls_type_d = 3'd0;
    end else if ((nseg_q == 2'd1) && in_first_q && !in_last_q) begin
      cls_type_d = 3'd1;
      cls_hi_d   = first_end_q;
    end else if ((nseg_q == 2'd1) && !in_first_q && in_last_q) begin
      cls_type_d = 3'd2;
      cls_lo_d   = last_start_q;
      cls_hi_d   = BinLast;
    end else if ((nseg_q == 2'd1) && !in_first_q && !in_last_q) begin
      cls_type_d = 3'd3;
      cls_lo_d   = last_start_q;
      cls_hi_d   = first_end_q;
    end else if ((nseg_q == 2'd2) && in_first_q && in_last_q) begin
      cls_type_d = 3'd4;
      cls_lo_d   = first_end_q;
      cls_hi_d   = last_start_q;
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      pk_q         <= '0;
      thr_q        <= '0;
      prev_in_q    <= 1'b0;
      in_first_q   <= 1'b0;
      in_last_q    <= 1'b0;
      nseg_q       <= '0;
      first_end_q  <= '0;
      last_start_q <= '0;
      cls_type_q   <= '0;
      cls_lo_q     <= '0;
      cls_hi_q     <= '0;
    end else begin
      pk_q <= (state_q == StIdle) ? '0 : pk_d;
      // Threshold taken from pk_d so the final PEAK sample is included.
      if ((state_q == StPeak) && (state_d == StBand)) thr_q <= thr_d;
      if ((state_q == StBand) && smp_vld) begin
        prev_in_q <= in_band;
        if (smp_idx == '0) begin
          in_first_q <= in_band;
          nseg_q     <= in_band ? 2'd1 : 2'd0;
          if (in_band) begin
            first_end_q  <= '0;
            last_start_q <= '0;
          end
        end else begin
          if (in_band && !prev_in_q) begin
            if (nseg_q != 2'd3) nseg_q <= nseg_q + 2'd1;
            last_start_q <= smp_idx;
          end
          // Grow first_end only while the first segment is the one being swept.
          if (in_band && ((prev_in_q && (nseg_q == 2'd1)) || (!prev_in_q && (nseg_q == 2'd0))))
            first_end_q <= smp_idx;
        end
        if (smp_idx == BinLast) in_last_q <= in_band;
      end
      if (state_q == StClass) begin
        cls_type_q <= cls_type_d;
        cls_lo_q   <= cls_lo_d;
        cls_hi_q   <= cls_hi_d;
      end
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      done        <= 1'b0;
      filter_type <= '0;
      f_low       <= '0;
      f_high      <= '0;
      peak_mag    <= '0;
    end else begin
      done <= commit;
      if (commit) begin
        filter_type <= cls_type_q;
        f_low       <= cls_lo_q;
        f_high      <= cls_hi_q;
        peak_mag    <= pk_q;
      end
    end
  end

endmodule

// File: tb/tb_filter_classify.sv
// tb_filter_classify: drives filter_classify against a behavioural 2-cycle RAM and compares the
// results with directed constants and with a bin-level reference model.
module tb_filter_classify;
  localparam int NP      = 64;
  localparam int AW      = 12;
  localparam int DW      = 16;
  localparam int LAT     = 2;
  localparam int EXP_LAT = 2 * (NP + LAT) + 3;

  logic          clk_50m = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy, done;
  logic [2:0]    filter_type;
  logic [AW-1:0] f_low, f_high;
  logic [DW:0]   peak_mag;

  filter_classify_if #(.ADDR_W(AW), .DATA_W(DW)) ram ();

  filter_classify #(.N_PTS(NP), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
    .clk_50m     (clk_50m),
    .rst_n       (rst_n),
    .start       (start),
    .ram         (ram),
    .busy        (busy),
    .done        (done),
    .filter_type (filter_type),
    .f_low       (f_low),
    .f_high      (f_high),
    .peak_mag    (peak_mag)
  );

  always #10 clk_50m = ~clk_50m;

  logic signed [DW-1:0] re_mem [NP];
  logic signed [DW-1:0] im_mem [NP];
  logic [DW-1:0]        d1_re, d1_im;
  int checks = 0;
  int passes = 0;
  int addr_err = 0;
  int exp_addr = 0;

  // Two-stage RAM read; junk on the bus when not enabled.
  always @(posedge clk_50m) begin
    if (ram.rd_en && (ram.rd_addr < AW'(NP))) begin
      d1_re <= re_mem[ram.rd_addr[5:0]];
      d1_im <= im_mem[ram.rd_addr[5:0]];
    end else begin
      d1_re <= DW'($urandom);
      d1_im <= DW'($urandom);
    end
    ram.rd_real <= d1_re;
    ram.rd_imag <= d1_im;
  end

  // Address sweep must be 0,1,2,... while enabled and 0 otherwise.
  always @(negedge clk_50m) begin
    if (ram.rd_en) begin
      if ((int'(ram.rd_addr) != exp_addr) || (int'(ram.rd_addr) >= NP)) addr_err <= addr_err + 1;
      exp_addr <= int'(ram.rd_addr) + 1;
    end else begin
      if (ram.rd_addr != '0) addr_err <= addr_err + 1;
      exp_addr <= 0;
    end
  end

  function automatic int abs_sat(input int v);
    if (v == -(1 << (DW - 1))) return (1 << (DW - 1)) - 1;
    return (v < 0) ? -v : v;
  endfunction

  // Reference: magnitudes, peak, -3 dB mask, then list the in-band runs and apply the rules.
  task automatic model(output int typ, output int lo, output int hi, output int pk);
    int mag [NP];
    int thr;
    int run_s [$];
    int run_e [$];
    bit first_in, last_in;
    pk = 0;
    for (int i = 0; i < NP; i++) begin
      mag[i] = abs_sat(int'(re_mem[i])) + abs_sat(int'(im_mem[i]));
      if (mag[i] > pk) pk = mag[i];
    end
    thr = (pk * 181) / 256;
    for (int i = 0; i < NP; i++) begin
      if (mag[i] >= thr) begin
        if (i == 0) run_s.push_back(i);
        else if (mag[i-1] < thr) run_s.push_back(i);
        if (i == NP - 1) run_e.push_back(i);
        else if (mag[i+1] < thr) run_e.push_back(i);
      end
    end
    first_in = (mag[0] >= thr);
    last_in  = (mag[NP-1] >= thr);
    typ = 0; lo = 0; hi = 0;
    if (pk == 0) typ = 0;
    else if (run_s.size() == 1 && first_in && !last_in) begin typ = 1; hi = run_e[0]; end
    else if (run_s.size() == 1 && !first_in && last_in) begin
      typ = 2; lo = run_s[0]; hi = NP - 1;
    end else if (run_s.size() == 1 && !first_in && !last_in) begin
      typ = 3; lo = run_s[0]; hi = run_e[0];
    end else if (run_s.size() == 2 && first_in && last_in) begin
      typ = 4; lo = run_e[0]; hi = run_s[1];
    end
  endtask

  task automatic load_band(input int lo_b, input int hi_b, input int in_v, input int out_v);
    for (int i = 0; i < NP; i++) begin
      re_mem[i] = (i >= lo_b && i <= hi_b) ? DW'(in_v) : DW'(out_v);
      im_mem[i] = '0;
    end
  endtask

  // Produces one fresh rising edge on start and waits (bounded) for done.
  task automatic run_once(output int lat, output bit got);
    lat = 0; got = 1'b0;
    start = 1'b0;
    @(posedge clk_50m); #1 start = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk_50m); #1;
      if (done) begin lat = c; got = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0;
    #15;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done: got %0b want 0", done); else passes++;
    checks++; if (filter_type !== 3'd0) $display("FAIL reset_type: got %0d want 0", filter_type); else passes++;
    checks++; if (f_low !== '0 || f_high !== '0) $display("FAIL reset_edges: got %0d/%0d want 0/0", f_low, f_high); else passes++;
    checks++; if (peak_mag !== '0) $display("FAIL reset_peak: got %0d want 0", peak_mag); else passes++;
    checks++; if (ram.rd_en !== 1'b0 || ram.rd_addr !== '0) $display("FAIL reset_rd: got en=%0b addr=%0d want 0/0", ram.rd_en, ram.rd_addr); else passes++;
    @(negedge clk_50m); rst_n = 1'b1;
    repeat (2) @(posedge clk_50m);
    #1;
  endtask

  task automatic test_shapes();
    int sh_lo [4] = '{0, 40, 20, 25};
    int sh_hi [4] = '{19, 63, 30, 35};
    int sh_in [4] = '{1000, 1000, 1000, 100};
    int sh_out[4] = '{100, 100, 100, 1000};
    int e_typ [4] = '{1, 2, 3, 4};
    int e_lo  [4] = '{0, 40, 20, 24};
    int e_hi  [4] = '{19, 63, 30, 36};
    int lat; bit got;
    for (int k = 0; k < 4; k++) begin
      load_band(sh_lo[k], sh_hi[k], sh_in[k], sh_out[k]);
      run_once(lat, got);
      checks++; if (!got || lat != EXP_LAT) $display("FAIL shape%0d_latency: got %0d (done=%0b) want %0d", k, lat, got, EXP_LAT); else passes++;
      checks++; if (int'(filter_type) != e_typ[k]) $display("FAIL shape%0d_type: got %0d want %0d", k, filter_type, e_typ[k]); else passes++;
      checks++; if (int'(f_low) != e_lo[k]) $display("FAIL shape%0d_f_low: got %0d want %0d", k, f_low, e_lo[k]); else passes++;
      checks++; if (int'(f_high) != e_hi[k]) $display("FAIL shape%0d_f_high: got %0d want %0d", k, f_high, e_hi[k]); else passes++;
      checks++; if (int'(peak_mag) != 1000) $display("FAIL shape%0d_peak: got %0d want 1000", k, peak_mag); else passes++;
    end
  endtask

  task automatic test_threshold();
    int lat; bit got;
    // 707 is the exact threshold for a 1000 peak; 706 falls just below it.
    load_band(0, 9, 1000, 0);
    re_mem[10] = -16'sd500; im_mem[10] = 16'sd207;
    re_mem[11] = 16'sd706;
    run_once(lat, got);
    checks++; if (filter_type !== 3'd1 || f_high !== AW'(10)) $display("FAIL thr_707_in: got type %0d f_high %0d want 1/10", filter_type, f_high); else passes++;
    checks++; if (f_low !== '0 || peak_mag !== 17'd1000) $display("FAIL thr_707_lo_peak: got %0d/%0d want 0/1000", f_low, peak_mag); else passes++;
    load_band(0, 9, 1000, 0);
    re_mem[10] = 16'sd706;
    run_once(lat, got);
    checks++; if (filter_type !== 3'd1 || f_high !== AW'(9)) $display("FAIL thr_706_out: got type %0d f_high %0d want 1/9", filter_type, f_high); else passes++;
  endtask

  task automatic test_zero_flat();
    int lat; bit got;
    load_band(0, NP - 1, 0, 0);
    run_once(lat, got);
    checks++; if (!got || filter_type !== 3'd0) $display("FAIL zero_type: got %0d (done=%0b) want 0", filter_type, got); else passes++;
    checks++; if (peak_mag !== '0 || f_low !== '0 || f_high !== '0) $display("FAIL zero_vals: got pk %0d lo %0d hi %0d want 0/0/0", peak_mag, f_low, f_high); else passes++;
    load_band(0, NP - 1, 500, 500);
    run_once(lat, got);
    checks++; if (filter_type !== 3'd0 || f_low !== '0 || f_high !== '0) $display("FAIL flat_type: got %0d lo %0d hi %0d want 0/0/0", filter_type, f_low, f_high); else passes++;
    checks++; if (peak_mag !== 17'd500) $display("FAIL flat_peak: got %0d want 500", peak_mag); else passes++;
  endtask

  task automatic test_saturation();
    int lat; bit got;
    load_band(0, NP - 1, 0, 0);
    re_mem[5] = 16'sh8000;
    run_once(lat, got);
    checks++; if (peak_mag !== 17'd32767) $display("FAIL sat_re_peak: got %0d want 32767", peak_mag); else passes++;
    checks++; if (filter_type !== 3'd3 || f_low !== AW'(5) || f_high !== AW'(5)) $display("FAIL sat_re_band: got %0d %0d..%0d want 3 5..5", filter_type, f_low, f_high); else passes++;
    im_mem[5] = 16'sh8000;
    run_once(lat, got);
    checks++; if (peak_mag !== 17'd65534) $display("FAIL sat_both_peak: got %0d want 65534", peak_mag); else passes++;
  endtask

  task automatic test_random();
    int lat, typ, lo, hi, pk, shape, a, b, amp;
    bit got, inb;
    for (int it = 0; it < 8; it++) begin
      shape = int'($urandom_range(0, 4));
      a = int'($urandom_range(1, 30));
      b = int'($urandom_range(a + 2, 62));
      for (int i = 0; i < NP; i++) begin
        case (shape)
          0:       inb = (i <= b);
          1:       inb = (i >= a);
          2:       inb = (i >= a && i <= b);
          3:       inb = !(i >= a && i <= b);
          default: inb = 1'($urandom_range(0, 1));
        endcase
        amp = inb ? int'($urandom_range(800, 1000)) : int'($urandom_range(0, 500));
        re_mem[i] = ($urandom_range(0, 1) == 1) ? DW'(-amp) : DW'(amp);
        im_mem[i] = DW'(int'($urandom_range(0, 100)) - 50);
      end
      model(typ, lo, hi, pk);
      run_once(lat, got);
      checks++; if (!got || lat != EXP_LAT) $display("FAIL rnd%0d_latency: got %0d (done=%0b) want %0d", it, lat, got, EXP_LAT); else passes++;
      checks++; if (int'(filter_type) != typ) $display("FAIL rnd%0d_type: got %0d want %0d", it, filter_type, typ); else passes++;
      checks++; if (int'(f_low) != lo || int'(f_high) != hi) $display("FAIL rnd%0d_edges: got %0d..%0d want %0d..%0d", it, f_low, f_high, lo, hi); else passes++;
      checks++; if (int'(peak_mag) != pk) $display("FAIL rnd%0d_peak: got %0d want %0d", it, peak_mag, pk); else passes++;
    end
  endtask

  // start held high across and after the run, with an unsampled glitch at cycle 50.
  task automatic test_held_start();
    int lat = 0;
    int n_done = 0;
    load_band(0, 19, 1000, 100);
    start = 1'b0;
    @(posedge clk_50m); #1 start = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk_50m); #1;
      if (done) begin n_done++; if (lat == 0) lat = c; end
      if (c == 50) begin start = 1'b0; #2 start = 1'b1; end
    end
    checks++; if (lat != EXP_LAT) $display("FAIL held_latency: got %0d want %0d", lat, EXP_LAT); else passes++;
    checks++; if (n_done != 1) $display("FAIL held_done_count: got %0d want 1", n_done); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL held_no_rerun: got busy %0b want 0", busy); else passes++;
    checks++; if (filter_type !== 3'd1 || f_high !== AW'(19)) $display("FAIL held_result: got %0d/%0d want 1/19", filter_type, f_high); else passes++;
    start = 1'b0;
  endtask

  task automatic test_abort();
    int lat; bit got;
    int n_done = 0;
    load_band(0, 19, 1000, 100);
    run_once(lat, got);
    checks++; if (!got) $display("FAIL abort_setup_done: got 0 want 1"); else passes++;
    load_band(40, 63, 1000, 100);
    start = 1'b0;
    @(posedge clk_50m); #1 start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk_50m); #1;
      if (done) n_done++;
    end
    checks++; if (busy !== 1'b1) $display("FAIL abort_busy_before: got %0b want 1", busy); else passes++;
    start = 1'b0;
    @(posedge clk_50m); #1;
    checks++; if (busy !== 1'b0) $display("FAIL abort_busy_after: got %0b want 0", busy); else passes++;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk_50m); #1;
      if (done) n_done++;
    end
    checks++; if (n_done != 0) $display("FAIL abort_no_done: got %0d pulses want 0", n_done); else passes++;
    checks++; if (filter_type !== 3'd1 || f_low !== '0 || f_high !== AW'(19)) $display("FAIL abort_held: got %0d %0d..%0d want 1 0..19", filter_type, f_low, f_high); else passes++;
    checks++; if (peak_mag !== 17'd1000) $display("FAIL abort_held_peak: got %0d want 1000", peak_mag); else passes++;
  endtask

  task automatic test_reset_mid();
    int lat; bit got;
    load_band(40, 63, 1000, 100);
    start = 1'b0;
    @(posedge clk_50m); #1 start = 1'b1;
    repeat (30) @(posedge clk_50m);
    #5 rst_n = 1'b0;
    #1;
    checks++; if (filter_type !== 3'd0 || f_high !== '0 || peak_mag !== '0) $display("FAIL rstmid_outputs: got %0d/%0d/%0d want 0/0/0", filter_type, f_high, peak_mag); else passes++;
    checks++; if (busy !== 1'b0 || ram.rd_en !== 1'b0) $display("FAIL rstmid_busy_rd: got %0b/%0b want 0/0", busy, ram.rd_en); else passes++;
    start = 1'b0;
    @(negedge clk_50m); rst_n = 1'b1;
    run_once(lat, got);
    checks++; if (!got || lat != EXP_LAT || filter_type !== 3'd2 || f_low !== AW'(40)) $display("FAIL rstmid_recover: got lat %0d type %0d lo %0d want %0d/2/40", lat, filter_type, f_low, EXP_LAT); else passes++;
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_shapes();
    test_threshold();
    test_zero_flat();
    test_saturation();
    test_random();
    test_held_start();
    test_abort();
    test_reset_mid();
    repeat (2) @(posedge clk_50m);
    checks++; if (addr_err != 0) $display("FAIL rd_addr_sweep: got %0d bad cycles want 0", addr_err); else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
